// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_SIM   = 16;
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 1_000_000;

endpackage

// File: rtl/bit_synchronizer.sv
// Plain shift-chain synchroniser for one asynchronous bit; q is the last stage.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_pulse_conditioner.sv
// Synchronise, debounce and edge-detect a raw button into one enable pulse per press.
module button_pulse_conditioner
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic enable_pulse,
    output logic button_level
);

    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 sync_out;
    btn_state_e           state;
    logic [CNT_WIDTH-1:0] cnt;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button_in),
        .q     (sync_out)
    );

    // The counter is only compared for equality and is cleared on every exit, so it tops out at CNT_MAX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            enable_pulse <= 1'b0;
            button_level <= 1'b0;
        end else begin
            enable_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sync_out) begin
                        state <= ARM_PRESS;
                        cnt   <= CNT_ONE;
                    end
                end
                ARM_PRESS: begin
                    if (!sync_out) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state        <= PRESSED;
                        cnt          <= '0;
                        enable_pulse <= 1'b1;
                        button_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_out) begin
                        state <= ARM_RELEASE;
                        cnt   <= CNT_ONE;
                    end
                end
                ARM_RELEASE: begin
                    if (sync_out) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        button_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    button_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboarded bench: default-debounce instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_button_pulse_conditioner;

    logic clk;
    logic reset;
    logic button0;
    logic button1;
    logic pulse0;
    logic level0;
    logic pulse1;
    logic level1;
    logic [3:0] enable_cnt;

    int cyc;
    int n_tests;
    int n_fail;
    int exp_q0[$];
    int exp_q1[$];
    logic prev0;
    logic prev1;

    button_pulse_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button0),
        .enable_pulse (pulse0),
        .button_level (level0)
    );

    button_pulse_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button1),
        .enable_pulse (pulse1),
        .button_level (level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Four-bit enable counter fed by the conditioned pulse
    always @(posedge clk) begin
        if (!reset) enable_cnt <= 4'd0;
        else if (pulse0) enable_cnt <= enable_cnt + 4'd1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: every pulse must match the oldest expected edge number
    always @(negedge clk) begin
        int e;
        if (exp_q0.size() > 0 && exp_q0[0] < cyc) begin
            e = exp_q0.pop_front();
            check_eq("p0_missed", cyc, e);
        end
        if (pulse0) begin
            e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 0;
            check_eq("p0_time", cyc, e);
            check_eq("p0_double", int'(prev0), 0);
        end
        if (exp_q1.size() > 0 && exp_q1[0] < cyc) begin
            e = exp_q1.pop_front();
            check_eq("p1_missed", cyc, e);
        end
        if (pulse1) begin
            e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 0;
            check_eq("p1_time", cyc, e);
            check_eq("p1_double", int'(prev1), 0);
        end
        prev0 = pulse0;
        prev1 = pulse1;
    end

    initial begin
        int c;
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        prev0   = 1'b0;
        prev1   = 1'b0;
        reset   = 1'b0;
        button0 = 1'b0;
        button1 = 1'b0;

        tick(2);
        check_eq("rst_pulse0", int'(pulse0), 0);
        check_eq("rst_level0", int'(level0), 0);
        check_eq("rst_pulse1", int'(pulse1), 0);
        check_eq("rst_level1", int'(level1), 0);
        reset = 1'b1;
        tick(3);

        // Clean press held 40 cycles, then release
        c = cyc;
        button0 = 1'b1;
        exp_q0.push_back(c + 19);
        tick(18);
        check_eq("clean_lvl_before", int'(level0), 0);
        check_eq("clean_pulse_before", int'(pulse0), 0);
        tick(1);
        check_eq("clean_lvl_on", int'(level0), 1);
        check_eq("clean_pulse_on", int'(pulse0), 1);
        tick(1);
        check_eq("clean_pulse_off", int'(pulse0), 0);
        tick(20);
        c = cyc;
        button0 = 1'b0;
        tick(18);
        check_eq("clean_rel_hold", int'(level0), 1);
        tick(1);
        check_eq("clean_rel_fall", int'(level0), 0);
        tick(20);

        // Press bounce: 3-cycle toggles, then hold
        for (int i = 0; i < 10; i++) begin
            button0 = (i % 2 == 0);
            tick(3);
        end
        c = cyc;
        button0 = 1'b1;
        exp_q0.push_back(c + 19);
        tick(25);
        check_eq("pbounce_lvl", int'(level0), 1);

        // Release bounce: level must stay high through 4-cycle toggles
        for (int i = 0; i < 6; i++) begin
            button0 = (i % 2 == 1);
            for (int j = 0; j < 4; j++) begin
                tick(1);
                check_eq("rbounce_lvl", int'(level0), 1);
            end
        end
        c = cyc;
        button0 = 1'b0;
        tick(18);
        check_eq("rbounce_hold", int'(level0), 1);
        tick(1);
        check_eq("rbounce_fall", int'(level0), 0);
        tick(10);

        // Reset mid-press at edge N+10, button held throughout
        c = cyc;
        button0 = 1'b1;
        tick(10);
        reset = 1'b0;
        tick(1);
        check_eq("midrst_pulse", int'(pulse0), 0);
        check_eq("midrst_lvl", int'(level0), 0);
        reset = 1'b1;
        exp_q0.push_back(c + 30);
        tick(25);
        check_eq("midrst_lvl_after", int'(level0), 1);
        button0 = 1'b0;
        tick(25);

        // Reset coincides with the completing press edge
        c = cyc;
        button0 = 1'b1;
        tick(18);
        reset = 1'b0;
        tick(1);
        check_eq("simrst_pulse", int'(pulse0), 0);
        check_eq("simrst_lvl", int'(level0), 0);
        reset = 1'b1;
        exp_q0.push_back(c + 38);
        tick(25);
        button0 = 1'b0;
        tick(25);

        // Three presses into the enable counter
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check_eq("cnt_start", int'(enable_cnt), 0);
        for (int k = 1; k <= 3; k++) begin
            c = cyc;
            button0 = 1'b1;
            exp_q0.push_back(c + 19);
            tick(25);
            button0 = 1'b0;
            tick(40);
            check_eq("cnt_step", int'(enable_cnt), k);
        end

        // DEBOUNCE_CYCLES=1: one-sample glitch is rejected
        button1 = 1'b1;
        tick(1);
        button1 = 1'b0;
        tick(10);
        check_eq("min_glitch_lvl", int'(level1), 0);

        // DEBOUNCE_CYCLES=1: two samples are accepted
        c = cyc;
        button1 = 1'b1;
        exp_q1.push_back(c + 4);
        tick(2);
        button1 = 1'b0;
        tick(2);
        check_eq("min_press_lvl", int'(level1), 1);
        check_eq("min_press_pulse", int'(pulse1), 1);
        tick(2);
        check_eq("min_rel_lvl", int'(level1), 0);
        tick(10);

        check_eq("q0_drained", exp_q0.size(), 0);
        check_eq("q1_drained", exp_q1.size(), 0);
        check_eq("cnt_final", int'(enable_cnt), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
